// File: rtl/exception_ctrl.sv
// Exception sequencer: saves EPC, fetches the handler byte from vector 253..255, loads it into PC.
// Busy for 2 + MEM_LATENCY cycles after the request edge; further requests are dropped while busy.
module exception_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  ctrl_iord,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [2:0]  iord_sel,
  output logic        mem_read,
  output logic [31:0] epc_value,
  output logic        epc_write,
  output logic [31:0] pc_value,
  output logic        pc_write,
  output logic [1:0]  exc_cause,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SAVE = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] epc_reg;
  logic [1:0]  cause_reg;
  logic [1:0]  cause_nxt;
  logic        exc_any;
  logic [2:0]  vec_sel;
  logic        unused_mem_hi;

  assign unused_mem_hi = ^mem_data[31:8];
  assign exc_any       = exc_opcode | exc_overflow | exc_div0;

  always_comb begin
    cause_nxt = 2'b00;
    if (exc_opcode)        cause_nxt = 2'b01;
    else if (exc_overflow) cause_nxt = 2'b10;
    else if (exc_div0)     cause_nxt = 2'b11;
  end

  always_comb begin
    case (cause_reg)
      2'b01:   vec_sel = 3'b010;
      2'b10:   vec_sel = 3'b011;
      default: vec_sel = 3'b100;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      epc_reg   <= 32'd0;
      cause_reg <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (exc_any) begin
            cause_reg <= cause_nxt;
            epc_reg   <= pc_in - 32'd4;
          end
        end
        S_SAVE:  cnt <= CNT_INIT;
        S_WAIT:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state alone so an async reset drops them at once.
  always_comb begin
    state_nxt = state;
    iord_sel  = ctrl_iord;
    mem_read  = 1'b0;
    epc_write = 1'b0;
    pc_write  = 1'b0;
    pc_value  = 32'd0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (exc_any) state_nxt = S_SAVE;
      end
      S_SAVE: begin
        iord_sel  = vec_sel;
        mem_read  = 1'b1;
        epc_write = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        iord_sel = vec_sel;
        mem_read = 1'b1;
        busy     = 1'b1;
        if (cnt == 4'd0) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        iord_sel  = vec_sel;
        pc_write  = 1'b1;
        pc_value  = {24'd0, mem_data[7:0]};
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign epc_value = epc_reg;
  assign exc_cause = cause_reg;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with three latency variants sharing one stimulus bus.
module tb_exception_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  ctrl_iord;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data;

  logic [2:0]  iord_sel_l1, iord_sel_l4, iord_sel_l3;
  logic        mem_read_l1, mem_read_l4, mem_read_l3;
  logic [31:0] epc_value_l1, epc_value_l4, epc_value_l3;
  logic        epc_write_l1, epc_write_l4, epc_write_l3;
  logic [31:0] pc_value_l1, pc_value_l4, pc_value_l3;
  logic        pc_write_l1, pc_write_l4, pc_write_l3;
  logic [1:0]  exc_cause_l1, exc_cause_l4, exc_cause_l3;
  logic        busy_l1, busy_l4, busy_l3;

  int n_checks = 0;
  int n_fail   = 0;

  exception_ctrl #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data),
    .iord_sel(iord_sel_l1), .mem_read(mem_read_l1), .epc_value(epc_value_l1),
    .epc_write(epc_write_l1), .pc_value(pc_value_l1), .pc_write(pc_write_l1),
    .exc_cause(exc_cause_l1), .busy(busy_l1)
  );

  exception_ctrl #(.MEM_LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data),
    .iord_sel(iord_sel_l4), .mem_read(mem_read_l4), .epc_value(epc_value_l4),
    .epc_write(epc_write_l4), .pc_value(pc_value_l4), .pc_write(pc_write_l4),
    .exc_cause(exc_cause_l4), .busy(busy_l4)
  );

  exception_ctrl #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data),
    .iord_sel(iord_sel_l3), .mem_read(mem_read_l3), .epc_value(epc_value_l3),
    .epc_write(epc_write_l3), .pc_value(pc_value_l3), .pc_write(pc_write_l3),
    .exc_cause(exc_cause_l3), .busy(busy_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    ctrl_iord    = 3'b000;
    exc_opcode   = 1'b0;
    exc_overflow = 1'b0;
    exc_div0     = 1'b0;
    pc_in        = 32'd0;
    mem_data     = 32'd0;

    #2;
    check("rst_busy",   {31'd0, busy_l1},      32'd0);
    check("rst_cause",  {30'd0, exc_cause_l1}, 32'd0);
    check("rst_epc",    epc_value_l1,          32'd0);
    check("rst_pcw",    {31'd0, pc_write_l1},  32'd0);
    check("rst_epcw",   {31'd0, epc_write_l1}, 32'd0);
    idle_cycles(2);
    reset_n = 1'b1;

    // Idle pass-through walk
    for (int i = 0; i < 8; i++) begin
      tick();
      ctrl_iord = 3'(i);
      #1;
      check("idle_iord_l1", {29'd0, iord_sel_l1}, i);
      check("idle_iord_l4", {29'd0, iord_sel_l4}, i);
      check("idle_busy",    {31'd0, busy_l1},     32'd0);
      check("idle_epcw",    {31'd0, epc_write_l1}, 32'd0);
      check("idle_pcw",     {31'd0, pc_write_l1},  32'd0);
      check("idle_cause",   {30'd0, exc_cause_l1}, 32'd0);
    end

    // Overflow with latency 1
    tick();
    ctrl_iord    = 3'b001;
    pc_in        = 32'h0000_0044;
    mem_data     = 32'h0000_00A0;
    exc_overflow = 1'b1;
    #1;
    check("ovf_pre_iord", {29'd0, iord_sel_l1}, 32'd1);
    tick();
    exc_overflow = 1'b0;
    check("ovf_save_epcw",  {31'd0, epc_write_l1}, 32'd1);
    check("ovf_save_epc",   epc_value_l1,          32'h0000_0040);
    check("ovf_save_iord",  {29'd0, iord_sel_l1},  32'd3);
    check("ovf_save_rd",    {31'd0, mem_read_l1},  32'd1);
    check("ovf_save_busy",  {31'd0, busy_l1},      32'd1);
    check("ovf_save_cause", {30'd0, exc_cause_l1}, 32'd2);
    check("ovf_save_pcw",   {31'd0, pc_write_l1},  32'd0);
    check("ovf_save_pcv",   pc_value_l1,           32'd0);
    tick();
    check("ovf_wait_iord",  {29'd0, iord_sel_l1},  32'd3);
    check("ovf_wait_epcw",  {31'd0, epc_write_l1}, 32'd0);
    check("ovf_wait_rd",    {31'd0, mem_read_l1},  32'd1);
    check("ovf_wait_busy",  {31'd0, busy_l1},      32'd1);
    check("ovf_wait_pcw",   {31'd0, pc_write_l1},  32'd0);
    tick();
    check("ovf_load_pcw",   {31'd0, pc_write_l1},  32'd1);
    check("ovf_load_pcv",   pc_value_l1,           32'h0000_00A0);
    check("ovf_load_iord",  {29'd0, iord_sel_l1},  32'd3);
    check("ovf_load_busy",  {31'd0, busy_l1},      32'd1);
    tick();
    check("ovf_done_busy",  {31'd0, busy_l1},      32'd0);
    check("ovf_done_iord",  {29'd0, iord_sel_l1},  32'd1);
    check("ovf_done_pcw",   {31'd0, pc_write_l1},  32'd0);
    check("ovf_done_pcv",   pc_value_l1,           32'd0);
    check("ovf_done_cause", {30'd0, exc_cause_l1}, 32'd2);
    check("ovf_done_epc",   epc_value_l1,          32'h0000_0040);
    idle_cycles(8);

    // All three causes together: opcode wins
    exc_opcode   = 1'b1;
    exc_overflow = 1'b1;
    exc_div0     = 1'b1;
    tick();
    exc_opcode   = 1'b0;
    exc_overflow = 1'b0;
    exc_div0     = 1'b0;
    check("pri3_iord",  {29'd0, iord_sel_l1},  32'd2);
    check("pri3_cause", {30'd0, exc_cause_l1}, 32'd1);
    idle_cycles(8);

    // Overflow and div0 together: overflow wins
    exc_overflow = 1'b1;
    exc_div0     = 1'b1;
    tick();
    exc_overflow = 1'b0;
    exc_div0     = 1'b0;
    check("pri2_iord",  {29'd0, iord_sel_l1},  32'd3);
    check("pri2_cause", {30'd0, exc_cause_l1}, 32'd2);
    idle_cycles(8);

    // Div0 with latency 4, opcode pulse during WAIT must be ignored
    ctrl_iord = 3'b101;
    pc_in     = 32'h0000_0100;
    mem_data  = 32'hDEAD_BE7C;
    exc_div0  = 1'b1;
    tick();
    exc_div0 = 1'b0;
    check("d0_save_iord",  {29'd0, iord_sel_l4},  32'd4);
    check("d0_save_epcw",  {31'd0, epc_write_l4}, 32'd1);
    check("d0_save_epc",   epc_value_l4,          32'h0000_00FC);
    check("d0_save_cause", {30'd0, exc_cause_l4}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      exc_opcode = (i == 1);
      check("d0_wait_iord",  {29'd0, iord_sel_l4},  32'd4);
      check("d0_wait_busy",  {31'd0, busy_l4},      32'd1);
      check("d0_wait_rd",    {31'd0, mem_read_l4},  32'd1);
      check("d0_wait_epcw",  {31'd0, epc_write_l4}, 32'd0);
      check("d0_wait_pcw",   {31'd0, pc_write_l4},  32'd0);
    end
    exc_opcode = 1'b0;
    tick();
    check("d0_load_pcw",   {31'd0, pc_write_l4},  32'd1);
    check("d0_load_pcv",   pc_value_l4,           32'h0000_007C);
    check("d0_load_iord",  {29'd0, iord_sel_l4},  32'd4);
    check("d0_load_busy",  {31'd0, busy_l4},      32'd1);
    check("d0_load_cause", {30'd0, exc_cause_l4}, 32'd3);
    tick();
    check("d0_done_busy",  {31'd0, busy_l4},      32'd0);
    check("d0_done_iord",  {29'd0, iord_sel_l4},  32'd5);
    check("d0_done_cause", {30'd0, exc_cause_l4}, 32'd3);
    idle_cycles(10);

    // PC wrap-around on EPC computation
    pc_in      = 32'd0;
    exc_opcode = 1'b1;
    tick();
    exc_opcode = 1'b0;
    check("wrap_epc",   epc_value_l1,          32'hFFFF_FFFC);
    check("wrap_cause", {30'd0, exc_cause_l1}, 32'd1);
    check("wrap_iord",  {29'd0, iord_sel_l1},  32'd2);
    idle_cycles(10);

    // Async reset in WAIT with latency 3
    ctrl_iord    = 3'b110;
    pc_in        = 32'h0000_0080;
    exc_overflow = 1'b1;
    tick();
    exc_overflow = 1'b0;
    tick();
    check("rw_wait_busy", {31'd0, busy_l3},     32'd1);
    check("rw_wait_iord", {29'd0, iord_sel_l3}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_busy",  {31'd0, busy_l3},      32'd0);
    check("rw_rd",    {31'd0, mem_read_l3},  32'd0);
    check("rw_iord",  {29'd0, iord_sel_l3},  32'd6);
    check("rw_epc",   epc_value_l3,          32'd0);
    check("rw_cause", {30'd0, exc_cause_l3}, 32'd0);
    check("rw_pcw",   {31'd0, pc_write_l3},  32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rw_after_pcw",  {31'd0, pc_write_l3}, 32'd0);
      check("rw_after_busy", {31'd0, busy_l3},     32'd0);
    end
    ctrl_iord = 3'b010;
    #1;
    check("rw_after_iord", {29'd0, iord_sel_l3}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 reached");
    $fatal(1);
  end

endmodule
